// File: rtl/ieee_conv_pkg.sv
// Shared definitions for the IEEE-754 <-> integer conversion blocks:
// rounding modes, converter state encoding and width-derived constants.
package ieee_conv_pkg;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RDN = 2'b10;
    localparam logic [1:0] RM_RUP = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_SHIFT  = 3'd2,
        S_ROUND  = 3'd3,
        S_DONE   = 3'd4
    } conv_state_t;

    function automatic int exp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Saturation constants are returned wide and truncated by the caller.
    function automatic logic [127:0] sat_pos(input int int_w);
        return (128'd1 << (int_w - 1)) - 128'd1;
    endfunction

    function automatic logic [127:0] sat_neg(input int int_w);
        return 128'd1 << (int_w - 1);
    endfunction

endpackage

// File: rtl/ieee_round_unit.sv
// Combinational round-increment decision from mode, sign and the
// lsb/guard/sticky bits of a truncated magnitude.
module ieee_round_unit
    import ieee_conv_pkg::*;
(
    input  logic [1:0] rm,
    input  logic       sign,
    input  logic       lsb,
    input  logic       guard,
    input  logic       sticky,
    output logic       inc
);

    always_comb begin
        inc = 1'b0;
        case (rm)
            RM_RNE: inc = guard & (sticky | lsb);
            RM_RTZ: inc = 1'b0;
            RM_RDN: inc = sign & (guard | sticky);
            RM_RUP: inc = ~sign & (guard | sticky);
            default: inc = 1'b0;
        endcase
    end

endmodule

// File: rtl/ieee_to_int_conv.sv
// Multi-cycle IEEE-754 to signed integer converter with an iterative
// alignment shifter, run-time rounding mode and saturation.
module ieee_to_int_conv
    import ieee_conv_pkg::*;
#(
    parameter int EXP_W      = 8,
    parameter int MAN_W      = 23,
    parameter int INT_W      = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_data,
    input  logic [1:0]             in_rm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INT_W-1:0]       out_data,
    output logic                   out_invalid,
    output logic                   out_overflow,
    output logic                   out_inexact,
    output logic                   busy
);

    localparam int BIAS = exp_bias(EXP_W);
    localparam int RW   = $clog2(INT_W + MAN_W + SHIFT_STEP + 3);
    localparam logic [RW-1:0]    STEP_R  = RW'(SHIFT_STEP);
    localparam logic [INT_W-1:0] SAT_POS = INT_W'(sat_pos(INT_W));
    localparam logic [INT_W-1:0] SAT_NEG = INT_W'(sat_neg(INT_W));

    conv_state_t state_q, state_d;

    logic [EXP_W+MAN_W:0] din_q;
    logic [1:0]           rm_q;
    logic                 sign_q, guard_q, sticky_q, left_q, special_q;
    logic [INT_W-1:0]     mag_q, res_q;
    logic [RW-1:0]        rem_q;
    logic                 inv_q, ovf_q, inx_q;

    // Field decode of the captured word
    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    logic             sign_f, exp_max, exp_zero;
    logic             is_nan, is_inf, is_big, neg_exact, is_special;
    int               e_val, d_val, neg_d;
    logic             dec_left;
    logic [RW-1:0]    dec_dist;
    logic [INT_W-1:0] sig_ext;

    always_comb begin
        sign_f   = din_q[EXP_W+MAN_W];
        exp_f    = din_q[EXP_W+MAN_W-1:MAN_W];
        man_f    = din_q[MAN_W-1:0];
        exp_max  = &exp_f;
        exp_zero = ~|exp_f;
        e_val    = exp_zero ? (1 - BIAS) : (int'({1'b0, exp_f}) - BIAS);
        d_val    = e_val - MAN_W;
        neg_d    = -d_val;
        dec_left = (d_val >= 0);
        if (dec_left)
            dec_dist = RW'(d_val);
        else if (neg_d > MAN_W + 2)
            dec_dist = RW'(MAN_W + 2);
        else
            dec_dist = RW'(neg_d);
        sig_ext    = {{(INT_W-MAN_W-1){1'b0}}, ~exp_zero, man_f};
        is_nan     = exp_max & (|man_f);
        is_inf     = exp_max & ~(|man_f);
        is_big     = ~exp_max & (e_val >= INT_W - 1);
        neg_exact  = is_big & sign_f & (e_val == INT_W - 1) & ~(|man_f);
        is_special = is_nan | is_inf | is_big;
    end

    // One alignment step; right shifts push bits through guard into sticky
    logic [RW-1:0]    step;
    logic [INT_W:0]   ext, ext_sh, ext_mask;
    logic             sticky_sh;
    logic [INT_W-1:0] mag_left;

    always_comb begin
        step      = (rem_q < STEP_R) ? rem_q : STEP_R;
        ext       = {mag_q, guard_q};
        ext_mask  = ~({(INT_W+1){1'b1}} << step);
        ext_sh    = ext >> step;
        sticky_sh = sticky_q | (|(ext & ext_mask));
        mag_left  = mag_q << step;
    end

    logic             round_inc;
    logic [INT_W-1:0] mag_inc;

    ieee_round_unit u_round (
        .rm     (rm_q),
        .sign   (sign_q),
        .lsb    (mag_q[0]),
        .guard  (guard_q),
        .sticky (sticky_q),
        .inc    (round_inc)
    );

    assign mag_inc = mag_q + {{(INT_W-1){1'b0}}, round_inc};

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_special || dec_dist == '0) state_d = S_ROUND;
                else                               state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (rem_q <= STEP_R) state_d = S_ROUND;
            end
            S_ROUND: state_d = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            din_q     <= '0;
            rm_q      <= RM_RNE;
            sign_q    <= 1'b0;
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
            left_q    <= 1'b0;
            special_q <= 1'b0;
            mag_q     <= '0;
            rem_q     <= '0;
            res_q     <= '0;
            inv_q     <= 1'b0;
            ovf_q     <= 1'b0;
            inx_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        din_q <= in_data;
                        rm_q  <= in_rm;
                    end
                end
                S_DECODE: begin
                    sign_q    <= sign_f;
                    guard_q   <= 1'b0;
                    sticky_q  <= 1'b0;
                    mag_q     <= sig_ext;
                    left_q    <= dec_left;
                    rem_q     <= is_special ? '0 : dec_dist;
                    special_q <= is_special;
                    if (is_special) begin
                        inx_q <= 1'b0;
                        if (is_nan) begin
                            res_q <= SAT_POS;
                            inv_q <= 1'b1;
                            ovf_q <= 1'b0;
                        end else if (neg_exact) begin
                            res_q <= SAT_NEG;
                            inv_q <= 1'b0;
                            ovf_q <= 1'b0;
                        end else begin
                            res_q <= sign_f ? SAT_NEG : SAT_POS;
                            inv_q <= 1'b0;
                            ovf_q <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    rem_q <= rem_q - step;
                    if (left_q) begin
                        mag_q <= mag_left;
                    end else begin
                        mag_q    <= ext_sh[INT_W:1];
                        guard_q  <= ext_sh[0];
                        sticky_q <= sticky_sh;
                    end
                end
                S_ROUND: begin
                    if (!special_q) begin
                        inv_q <= 1'b0;
                        // Rounding up to 2^(INT_W-1) is only representable when negative
                        if (!sign_q && mag_inc == SAT_NEG) begin
                            res_q <= SAT_POS;
                            ovf_q <= 1'b1;
                            inx_q <= 1'b0;
                        end else begin
                            res_q <= sign_q ? -mag_inc : mag_inc;
                            ovf_q <= 1'b0;
                            inx_q <= guard_q | sticky_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data     = res_q;
    assign out_invalid  = inv_q;
    assign out_overflow = ovf_q;
    assign out_inexact  = inx_q;

endmodule

// File: tb/tb_ieee_to_int_conv.sv
// Directed float32 -> int32 vectors with hand-computed results, latency,
// handshake hold and mid-conversion reset checks.
module tb_ieee_to_int_conv;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_invalid;
    logic        out_overflow;
    logic        out_inexact;
    logic        busy;

    int vectors    = 0;
    int miscompares = 0;

    ieee_to_int_conv dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_rm        (in_rm),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_invalid  (out_invalid),
        .out_overflow (out_overflow),
        .out_inexact  (out_inexact),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change #1 after a rising edge; outputs are sampled there too.
    task automatic run(input string tag, input logic [31:0] din, input logic [1:0] rm,
                       input logic [31:0] exp_d, input logic e_inv, input logic e_ovf,
                       input logic e_inx, input int exp_lat, input int hold);
        int k;
        logic [31:0] held;
        in_data  = din;
        in_rm    = rm;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".lat"},   64'(k), 64'(exp_lat));
        chk({tag, ".data"},  64'(out_data), 64'(exp_d));
        chk({tag, ".inv"},   64'(out_invalid), 64'(e_inv));
        chk({tag, ".ovf"},   64'(out_overflow), 64'(e_ovf));
        chk({tag, ".inx"},   64'(out_inexact), 64'(e_inx));
        held = out_data;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk({tag, ".hold_data"},  64'(out_data), 64'(held));
            chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, ".hold_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, ".post_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".post_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_rm     = 2'b00;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst.in_ready",  64'(in_ready), 64'd1);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.busy",      64'(busy), 64'd0);
        chk("rst.data",      64'(out_data), 64'd0);
        chk("rst.flags",     64'({out_invalid, out_overflow, out_inexact}), 64'd0);

        //     tag          data          rm     expected      inv   ovf   inx lat hold
        run("pi_rne",     32'h40490FDB, 2'b00, 32'h00000003, 1'b0, 1'b0, 1'b1, 8, 0);
        run("m2p5_rne",   32'hC0200000, 2'b00, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 8, 0);
        run("m2p5_rtz",   32'hC0200000, 2'b01, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 8, 0);
        run("m2p5_rup",   32'hC0200000, 2'b11, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 8, 0);
        run("m2p5_rdn",   32'hC0200000, 2'b10, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b1, 8, 0);
        run("left_exact", 32'h4E800000, 2'b00, 32'h40000000, 1'b0, 1'b0, 1'b0, 4, 5);
        run("int_min",    32'hCF000000, 2'b00, 32'h80000000, 1'b0, 1'b0, 1'b0, 2, 0);
        run("pos_2p31",   32'h4F000000, 2'b00, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 2, 0);
        run("qnan",       32'h7FC00000, 2'b00, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 2, 0);
        run("neg_inf",    32'hFF800000, 2'b00, 32'h80000000, 1'b0, 1'b1, 1'b0, 2, 0);
        run("neg_zero",   32'h80000000, 2'b00, 32'h00000000, 1'b0, 1'b0, 1'b0, 9, 0);
        run("half_rne",   32'h3F000000, 2'b00, 32'h00000000, 1'b0, 1'b0, 1'b1, 8, 0);
        run("half_rup",   32'h3F000000, 2'b11, 32'h00000001, 1'b0, 1'b0, 1'b1, 8, 0);
        run("ndenorm_rdn",32'h80000001, 2'b10, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 9, 0);

        // Reset while the alignment shifter is running
        in_data  = 32'h3F000000;
        in_rm    = 2'b00;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst.busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst.out_valid", 64'(out_valid), 64'd0);
        chk("midrst.in_ready",  64'(in_ready), 64'd1);
        chk("midrst.busy",      64'(busy), 64'd0);
        chk("midrst.data",      64'(out_data), 64'd0);

        run("after_rst",  32'h40490FDB, 2'b11, 32'h00000004, 1'b0, 1'b0, 1'b1, 8, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
